// File: rtl/step_generator_if.sv
// step_generator_if: CPU register bus between the address decoder (master) and a step generator (slave).
// Signals: enable (register select, held for the whole access), write (1 = write), addr_in (word index),
// data_in (write data), data_out (read data, zero when idle), ready (one-clock access acknowledge).
interface step_generator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic                  write;
  logic [2:0]            addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ready;
  modport master (output enable, write, addr_in, data_in, input data_out, ready);
  modport slave  (input enable, write, addr_in, data_in, output data_out, ready);
endinterface

// File: rtl/step_generator.sv
// step_generator: memory-mapped step/direction pulse generator for one stepper-driver channel.
// Ports: clk_in (system clock), reset_in (async active-high reset), bus (register slave port),
// step_out (step pulse, active high), dir_out (direction), busy_out (move in progress).
// Optional macro STEP_POSITION_EN adds the signed POSITION register at word 6.
module step_generator #(
  parameter int DATA_WIDTH       = 32,
  parameter int DIR_SETUP_CYCLES = 8,
  parameter int PULSE_WIDTH_BITS = 16
) (
  input  logic            clk_in,
  input  logic            reset_in,
  step_generator_if.slave bus,
  output logic            step_out,
  output logic            dir_out,
  output logic            busy_out
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;
  state_t r_state, w_next;
  logic r_en_d, r_ready, r_done, r_abort, r_step, r_dir;
  logic [DATA_WIDTH-1:0] r_period, r_count, r_rem, r_cnt, r_low;
  logic [PULSE_WIDTH_BITS-1:0] r_pulse;
  logic w_wr, w_rd, w_ctl, w_start, w_abort, w_set_done, w_high_entry, w_dec_rem, w_abort_nxt, w_cnt_zero;
  logic [DATA_WIDTH-1:0] w_pulse_eff, w_period_eff, w_cnt_nxt, w_rdata, w_pos_rd;
  assign w_wr        = r_ready & bus.write;
  assign w_rd        = r_ready & ~bus.write;
  assign w_ctl       = w_wr & (bus.addr_in == 3'd3);
  // abort wins over start in the same write
  assign w_start     = w_ctl & bus.data_in[0] & ~bus.data_in[2] & (r_state == S_IDLE);
  assign w_abort     = w_ctl & bus.data_in[2] & (r_state != S_IDLE);
  assign w_pulse_eff = (r_pulse == '0) ? DATA_WIDTH'(1) : DATA_WIDTH'(r_pulse);
  // period is stretched so the low time is never shorter than one clock
  assign w_period_eff = (r_period > w_pulse_eff) ? r_period : w_pulse_eff + DATA_WIDTH'(1);
  assign w_cnt_zero  = (r_cnt == '0);
  assign busy_out    = (r_state != S_IDLE);
  assign step_out    = r_step;
  assign dir_out     = r_dir;
  assign bus.ready   = r_ready;
  assign bus.data_out = r_ready & ~bus.write ? w_rdata : '0;
  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt - DATA_WIDTH'(1);
    w_set_done   = 1'b0;
    w_high_entry = 1'b0;
    w_dec_rem    = 1'b0;
    w_abort_nxt  = r_abort;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = 1'b0;
        if (w_start && r_count == '0) w_set_done = 1'b1;
        else if (w_start) begin
          w_next    = S_SETUP;
          w_cnt_nxt = DATA_WIDTH'(DIR_SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (w_abort) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end else if (w_cnt_zero) begin
          w_next       = S_HIGH;
          w_high_entry = 1'b1;
          w_cnt_nxt    = w_pulse_eff - DATA_WIDTH'(1);
        end
      end
      S_HIGH: begin
        // an abort during the high phase is remembered so the pulse completes at full width
        if (w_abort) w_abort_nxt = 1'b1;
        if (w_cnt_zero) begin
          w_dec_rem = 1'b1;
          if (r_abort || w_abort) begin
            w_next     = S_IDLE;
            w_set_done = 1'b1;
          end else begin
            w_next    = S_LOW;
            w_cnt_nxt = r_low - DATA_WIDTH'(1);
          end
        end
      end
      default: begin
        if (w_abort || (w_cnt_zero && r_rem == '0)) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end else if (w_cnt_zero) begin
          w_next       = S_HIGH;
          w_high_entry = 1'b1;
          w_cnt_nxt    = w_pulse_eff - DATA_WIDTH'(1);
        end
      end
    endcase
  end
  always_comb begin
    w_rdata = '0;
    case (bus.addr_in)
      3'd0:    w_rdata = r_period;
      3'd1:    w_rdata = DATA_WIDTH'(r_pulse);
      3'd2:    w_rdata = r_count;
      3'd4:    w_rdata = DATA_WIDTH'({r_done, busy_out});
      3'd5:    w_rdata = r_rem;
      3'd6:    w_rdata = w_pos_rd;
      default: w_rdata = '0;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state  <= S_IDLE;
      r_en_d   <= 1'b0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_step   <= 1'b0;
      r_dir    <= 1'b0;
      r_period <= '0;
      r_pulse  <= '0;
      r_count  <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_low    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
      r_step  <= (w_next == S_HIGH);
      r_en_d  <= bus.enable;
      r_ready <= bus.enable & ~r_en_d;
      // a done being set outranks a simultaneous STATUS-read clear
      r_done  <= w_set_done | (r_done & ~w_start & ~(w_rd & (bus.addr_in == 3'd4)));
      if (w_start) begin
        r_dir <= bus.data_in[1];
        r_rem <= r_count;
      end else if (w_dec_rem) r_rem <= r_rem - DATA_WIDTH'(1);
      // low time is frozen at each rising edge so PERIOD/PULSE writes only affect the next pulse
      if (w_high_entry) r_low <= w_period_eff - w_pulse_eff;
      if (w_wr && bus.addr_in == 3'd0) r_period <= bus.data_in;
      if (w_wr && bus.addr_in == 3'd1) r_pulse <= bus.data_in[PULSE_WIDTH_BITS-1:0];
      if (w_wr && bus.addr_in == 3'd2) r_count <= bus.data_in;
    end
  end
`ifdef STEP_POSITION_EN
  logic [DATA_WIDTH-1:0] r_pos;
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_pos <= '0;
    else if (w_high_entry) r_pos <= r_dir ? r_pos + DATA_WIDTH'(1) : r_pos - DATA_WIDTH'(1);
    else if (w_wr && bus.addr_in == 3'd6 && r_state == S_IDLE) r_pos <= bus.data_in;
  end
  assign w_pos_rd = r_pos;
`else
  assign w_pos_rd = '0;
`endif
endmodule

// File: tb/tb_step_generator.sv
// tb_step_generator: directed, table-driven checks of the step_generator register interface and pulse timing.
module tb_step_generator;
  localparam int DSC = 8;
  logic clk, rst, step_out, dir_out, busy_out;
  int n_cmp = 0, n_bad = 0;
  int hi_run = 0, last_hi = 0, pulses = 0;
  step_generator_if #(.DATA_WIDTH(32)) bus ();
  step_generator #(.DATA_WIDTH(32), .DIR_SETUP_CYCLES(DSC), .PULSE_WIDTH_BITS(16)) dut (
    .clk_in(clk), .reset_in(rst), .bus(bus), .step_out(step_out), .dir_out(dir_out), .busy_out(busy_out)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (step_out) hi_run = hi_run + 1;
    else if (hi_run != 0) begin
      last_hi = hi_run;
      pulses  = pulses + 1;
      hi_run  = 0;
    end
  end
  typedef struct {
    logic [31:0] period;
    logic [31:0] pulse;
    logic [31:0] count;
    logic        dir;
    int          hi;
    int          lo;
  } vec_t;
  vec_t vecs[4];
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] din, output logic [31:0] dout);
    int t;
    t = 0;
    @(negedge clk);
    bus.enable = 1'b1; bus.write = w; bus.addr_in = a; bus.data_in = din;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.ready && t < 8);
    dout = bus.data_out;
    check("ready_seen", {31'b0, bus.ready}, 32'd1);
    @(negedge clk);
    check("ready_one_clock", {31'b0, bus.ready}, 32'd0);
    check("data_out_idle_zero", bus.data_out, 32'd0);
    bus.enable = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] x;
    access(1'b1, a, d, x);
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    access(1'b0, a, 32'd0, d);
  endtask
  task automatic measure(output int hi, output int lo);
    hi = 0; lo = 0;
    while (step_out && hi < 1000) begin hi++; @(negedge clk); end
    while (!step_out && busy_out && lo < 1000) begin lo++; @(negedge clk); end
  endtask
  task automatic wait_idle();
    int c;
    c = 0;
    while (busy_out && c < 5000) begin @(negedge clk); c++; end
    check("idle_timeout", {31'b0, busy_out}, 32'd0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    int k, hi, lo, base;
    vecs[0] = '{period: 10, pulse: 3, count: 4, dir: 1'b1, hi: 3, lo: 7};
    vecs[1] = '{period: 2,  pulse: 5, count: 2, dir: 1'b0, hi: 5, lo: 1};
    vecs[2] = '{period: 4,  pulse: 0, count: 3, dir: 1'b1, hi: 1, lo: 3};
    vecs[3] = '{period: 0,  pulse: 0, count: 1, dir: 1'b0, hi: 1, lo: 1};
    bus.enable = 1'b0; bus.write = 1'b0; bus.addr_in = 3'd0; bus.data_in = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_step", {31'b0, step_out}, 32'd0);
    check("rst_dir", {31'b0, dir_out}, 32'd0);
    check("rst_busy", {31'b0, busy_out}, 32'd0);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    rst = 1'b0;
    // register field widths and write-only / unused words
    wr(3'd1, 32'h0001_2345);
    rd(3'd1, d); check("pulse_width_field", d, 32'h0000_2345);
    wr(3'd0, 32'hDEAD_BEEF);
    rd(3'd0, d); check("period_rw", d, 32'hDEAD_BEEF);
    rd(3'd3, d); check("control_reads_0", d, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, d); check("reg7_reads_0", d, 32'd0);
    // table-driven moves
    for (int v = 0; v < 4; v++) begin
      wr(3'd0, vecs[v].period);
      wr(3'd1, vecs[v].pulse);
      wr(3'd2, vecs[v].count);
      wr(3'd3, {30'b0, vecs[v].dir, 1'b1});
      check($sformatf("v%0d_dir", v), {31'b0, dir_out}, {31'b0, vecs[v].dir});
      k = 0;
      while (!step_out && k < 100) begin @(negedge clk); k++; end
      check($sformatf("v%0d_setup", v), k, DSC);
      for (int p = 0; p < int'(vecs[v].count); p++) begin
        measure(hi, lo);
        check($sformatf("v%0d_p%0d_high", v, p), hi, vecs[v].hi);
        check($sformatf("v%0d_p%0d_low", v, p), lo, vecs[v].lo);
      end
      check($sformatf("v%0d_busy_end", v), {31'b0, busy_out}, 32'd0);
      rd(3'd4, d); check($sformatf("v%0d_status", v), d, 32'h2);
      rd(3'd5, d); check($sformatf("v%0d_remaining", v), d, 32'd0);
    end
    // COUNT=0: immediate done, no pulse, sticky until read
    base = pulses;
    wr(3'd2, 32'd0);
    wr(3'd3, 32'h1);
    check("c0_busy", {31'b0, busy_out}, 32'd0);
    rd(3'd4, d); check("c0_status_first", d, 32'h2);
    rd(3'd4, d); check("c0_status_second", d, 32'h0);
    check("c0_no_pulse", pulses - base, 0);
    // abort during the 3rd high phase
    wr(3'd0, 32'd12);
    wr(3'd1, 32'd8);
    wr(3'd2, 32'd100);
    base = pulses;
    wr(3'd3, 32'h1);
    k = 0;
    while ((pulses - base < 2 || !step_out) && k < 2000) begin @(negedge clk); k++; end
    wr(3'd3, 32'h4);
    wait_idle();
    @(negedge clk);
    @(negedge clk);
    check("abort_pulses", pulses - base, 3);
    check("abort_full_width", last_hi, 8);
    check("abort_step_low", {31'b0, step_out}, 32'd0);
    rd(3'd4, d); check("abort_status", d, 32'h2);
    rd(3'd5, d); check("abort_remaining", d, 32'd97);
    // start while busy is ignored, COUNT written while busy is only stored
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd2);
    base = pulses;
    wr(3'd3, 32'h1);
    wr(3'd3, 32'h3);
    wr(3'd2, 32'd50);
    check("busy_start_dir", {31'b0, dir_out}, 32'd0);
    wait_idle();
    @(negedge clk);
    @(negedge clk);
    check("busy_start_pulses", pulses - base, 2);
    rd(3'd5, d); check("busy_start_remaining", d, 32'd0);
    rd(3'd2, d); check("busy_count_stored", d, 32'd50);
`ifdef STEP_POSITION_EN
    wr(3'd6, 32'h7FFF_FFFF);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'h3);
    wait_idle();
    rd(3'd6, d); check("pos_wrap_up", d, 32'h8000_0000);
    wr(3'd2, 32'd3);
    wr(3'd3, 32'h1);
    wait_idle();
    rd(3'd6, d); check("pos_down", d, 32'h7FFF_FFFD);
`else
    wr(3'd6, 32'h1234_5678);
    rd(3'd6, d); check("pos_absent_reads_0", d, 32'd0);
`endif
    // asynchronous reset in the middle of a move
    wr(3'd0, 32'd10);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd5);
    base = pulses;
    wr(3'd3, 32'h3);
    k = 0;
    while ((pulses - base < 2 || !step_out) && k < 2000) begin @(negedge clk); k++; end
    check("mid_step_high", {31'b0, step_out}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_step", {31'b0, step_out}, 32'd0);
    check("mid_rst_busy", {31'b0, busy_out}, 32'd0);
    check("mid_rst_dir", {31'b0, dir_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, d); check("mid_rst_period", d, 32'd0);
    rd(3'd1, d); check("mid_rst_pulse", d, 32'd0);
    rd(3'd2, d); check("mid_rst_count", d, 32'd0);
    rd(3'd4, d); check("mid_rst_status", d, 32'd0);
    rd(3'd5, d); check("mid_rst_remaining", d, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
